svm_dag_sequencer: RTL and testbench
====================================

// Module: svm_dag_sequencer
// PURPOSE
//  Parametrised one-vs-one DAG sequencer for sequential SVM classifiers. Runs N-1 binary
//  decisions on a shared SVM datapath, eliminating one class per decision.
//  Drives a pair index into the external coefficient ROM and reports the surviving class.
//  Supports any class count up to N_CLASSES, set at run time on each start.
// PARAMETERS
//  N_CLASSES  10                              max classes; must be >= 2
//  CLASS_W    $clog2(N_CLASSES)               width of class fields
//  N_PAIRS    N_CLASSES*(N_CLASSES-1)/2       number of ROM entries
//  IDX_W      $clog2(N_PAIRS)                 width of coef_idx
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        synchronous reset, active-high
//  start          in   1        start one classification; sampled only in IDLE
//  cfg_n_classes  in   CLASS_W+1  active class count n, latched on an accepted start
//  svm_valid      in   1        datapath has a result for the current pair
//  w_class        in   1        result: 0 = low class wins, 1 = high class wins
//  svm_start      out  1        one-cycle pulse: begin evaluating the current pair
//  coef_idx       out  IDX_W    ROM index of the current pair (lo,hi)
//  cls_lo         out  CLASS_W  low class of the current pair
//  cls_hi         out  CLASS_W  high class of the current pair
//  busy           out  1        high from the cycle after an accepted start until winner_valid
//  winner_valid   out  1        one-cycle pulse: winner is valid
//  winner         out  CLASS_W  winning class; held until the next winner_valid
// BEHAVIOUR
//  - Reset: state=IDLE; svm_start=0, busy=0, winner_valid=0, winner=0, coef_idx=0.
//    Also cls_lo=0, cls_hi=0.
//  - FSM IDLE->EVAL->DONE->IDLE. Every output is a register.
//  - IDLE, start=1:
//    - Latch n = clamp(cfg_n_classes, 2, N_CLASSES).
//    - Set lo=0, hi=n-1, coef_idx=0; go to EVAL.
//    - svm_start=1 in the first EVAL cycle.
//  - EVAL:
//    - coef_idx, cls_lo and cls_hi are stable throughout.
//    - svm_valid is ignored in the cycle where svm_start=1; it is accepted in any later EVAL cycle.
//  - Accepted svm_valid with hi-lo > 1:
//    - w_class=0: hi <= hi-1, coef_idx <= coef_idx+1.
//    - w_class=1: lo <= lo+1, coef_idx <= coef_idx + (n-1-lo).
//    - Re-pulse svm_start in the next cycle.
//  - Accepted svm_valid with hi-lo == 1:
//    - winner <= w_class ? hi : lo; go to DONE.
//  - DONE: winner_valid=1 and busy=0 for exactly one cycle; then IDLE.
//  - ROM layout for n: index = sum over k<lo of (n-1-k), plus (n-1-hi).
//    Ordered by lo ascending, then hi descending.
//  - Exactly n-1 decisions per classification.
//    - Minimum latency start->winner_valid = 2(n-1)+1 cycles when the datapath answers one cycle after svm_start.
//  - start while busy or in DONE: ignored; cfg_n_classes is not re-latched.
//  - svm_valid in IDLE or DONE: ignored.
//  - rst mid-operation: abort and return to reset values the next cycle; no winner_valid.
//  - Arithmetic: coef_idx adds are unsigned IDX_W.
//    - They cannot overflow because n <= N_CLASSES.
//    - lo < hi holds at all times in EVAL.
// CONFIGURATION
//  - SVM_DAG_PATH_EN defined:
//    - Extra output dag_path, width N_CLASSES-1, cleared on an accepted start.
//    - Bit i = w_class of decision i.
//    - Valid with winner_valid and held with winner; bits >= n-1 read 0.
//  - Not defined: port absent, no path register; all other behaviour identical.
// TESTING
//  - n=10, w_class=0 every decision:
//    - coef_idx 0,1,...,8, (lo,hi) ending at (0,1).
//    - winner=0 with one winner_valid pulse.
//  - n=10, w_class=1 every decision:
//    - coef_idx 0,9,17,24,30,35,39,42,44.
//    - winner=9; dag_path=9'h1FF when SVM_DAG_PATH_EN is defined.
//  - n=4, w_class 1,0,1:
//    - coef_idx 0,3,4 and pairs (0,3),(1,3),(1,2); winner=2.
//  - cfg_n_classes=1 (clamped to 2), w_class=1:
//    - One svm_start, coef_idx=0, winner=1.
//  - start pulsed during EVAL, plus svm_valid held high on the svm_start cycle:
//    - No restart and no double-step; decision count stays n-1.
//  - rst asserted after the 3rd decision:
//    - Next cycle all outputs at reset values, no winner_valid.
//    - A new start runs cleanly from coef_idx=0.

Source files
------------

// File: rtl/svm_dag_sequencer.sv
// One-vs-one DAG sequencer: walks N-1 pairwise SVM decisions on a shared datapath.
// Optional macro SVM_DAG_PATH_EN adds the dag_path_o decision-history output.
module svm_dag_sequencer #(
    parameter int N_CLASSES = 10,
    parameter int CLASS_W   = $clog2(N_CLASSES),
    parameter int N_PAIRS   = N_CLASSES * (N_CLASSES - 1) / 2,
    parameter int IDX_W     = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CLASS_W:0]   cfg_n_classes_i,
    input  logic               svm_valid_i,
    input  logic               w_class_i,
    output logic               svm_start_o,
    output logic [IDX_W-1:0]   coef_idx_o,
    output logic [CLASS_W-1:0] cls_lo_o,
    output logic [CLASS_W-1:0] cls_hi_o,
    output logic               busy_o,
    output logic               winner_valid_o,
    output logic [CLASS_W-1:0] winner_o
`ifdef SVM_DAG_PATH_EN
    ,
    output logic [N_CLASSES-2:0] dag_path_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    localparam logic [CLASS_W:0] N_MIN = (CLASS_W+1)'(2);
    localparam logic [CLASS_W:0] N_MAX = (CLASS_W+1)'(N_CLASSES);

    state_t             state_q, state_d;
    logic [CLASS_W:0]   n_q, n_d, n_clamp;
    logic [CLASS_W-1:0] lo_q, lo_d, hi_q, hi_d, winner_q, winner_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               svm_start_q, svm_start_d;
    logic               busy_q, busy_d;
    logic               winner_valid_q, winner_valid_d;
    logic               accept, last;
`ifdef SVM_DAG_PATH_EN
    logic [N_CLASSES-2:0] path_q, path_d;
    logic [CLASS_W:0]     dec_idx;
`endif

    // The datapath answer for a pair is only trusted after its svm_start cycle.
    assign accept = (state_q == S_EVAL) && svm_valid_i && !svm_start_q;
    assign last   = ((hi_q - lo_q) == CLASS_W'(1));

    always_comb begin
        if (cfg_n_classes_i < N_MIN)      n_clamp = N_MIN;
        else if (cfg_n_classes_i > N_MAX) n_clamp = N_MAX;
        else                              n_clamp = cfg_n_classes_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_EVAL;
            S_EVAL:  if (accept && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d            = n_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        idx_d          = idx_q;
        winner_d       = winner_q;
        svm_start_d    = 1'b0;
        busy_d         = busy_q;
        winner_valid_d = 1'b0;
`ifdef SVM_DAG_PATH_EN
        path_d  = path_q;
        dec_idx = {1'b0, lo_q} + (n_q - 1'b1 - {1'b0, hi_q});
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d         = n_clamp;
                    lo_d        = '0;
                    hi_d        = CLASS_W'(n_clamp - 1'b1);
                    idx_d       = '0;
                    svm_start_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef SVM_DAG_PATH_EN
                    path_d      = '0;
`endif
                end
            end
            S_EVAL: begin
                if (accept) begin
`ifdef SVM_DAG_PATH_EN
                    for (int i = 0; i < N_CLASSES - 1; i++)
                        if (dec_idx == (CLASS_W+1)'(i)) path_d[i] = w_class_i;
`endif
                    if (last) begin
                        winner_d       = w_class_i ? hi_q : lo_q;
                        busy_d         = 1'b0;
                        winner_valid_d = 1'b1;
                    end else begin
                        svm_start_d = 1'b1;
                        // Dropping lo skips the rest of its ROM row: n-1-lo entries.
                        if (w_class_i) begin
                            lo_d  = lo_q + 1'b1;
                            idx_d = idx_q + IDX_W'(n_q - 1'b1 - {1'b0, lo_q});
                        end else begin
                            hi_d  = hi_q - 1'b1;
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q            <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            idx_q          <= '0;
            winner_q       <= '0;
            svm_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            winner_valid_q <= 1'b0;
`ifdef SVM_DAG_PATH_EN
            path_q         <= '0;
`endif
        end else begin
            n_q            <= n_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            idx_q          <= idx_d;
            winner_q       <= winner_d;
            svm_start_q    <= svm_start_d;
            busy_q         <= busy_d;
            winner_valid_q <= winner_valid_d;
`ifdef SVM_DAG_PATH_EN
            path_q         <= path_d;
`endif
        end
    end

    assign svm_start_o    = svm_start_q;
    assign coef_idx_o     = idx_q;
    assign cls_lo_o       = lo_q;
    assign cls_hi_o       = hi_q;
    assign busy_o         = busy_q;
    assign winner_valid_o = winner_valid_q;
    assign winner_o       = winner_q;
`ifdef SVM_DAG_PATH_EN
    assign dag_path_o     = path_q;
`endif

endmodule

// File: tb/tb_svm_dag_sequencer.sv
// Scoreboard bench for svm_dag_sequencer: directed runs push expected pairs/winners,
// a negedge monitor pops and compares whenever svm_start or winner_valid is presented.
module tb_svm_dag_sequencer;
    localparam int N  = 10;
    localparam int CW = 4;
    localparam int IW = 6;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, svm_valid = 1'b0, w_class = 1'b0;
    logic [CW:0]   cfg = '0;
    logic          svm_start_o, busy_o, winner_valid_o;
    logic [IW-1:0] coef_idx_o;
    logic [CW-1:0] cls_lo_o, cls_hi_o, winner_o;
`ifdef SVM_DAG_PATH_EN
    logic [N-2:0]  dag_path_o;
`endif

    svm_dag_sequencer #(.N_CLASSES(N)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_n_classes_i(cfg),
        .svm_valid_i(svm_valid), .w_class_i(w_class),
        .svm_start_o(svm_start_o), .coef_idx_o(coef_idx_o), .cls_lo_o(cls_lo_o),
        .cls_hi_o(cls_hi_o), .busy_o(busy_o), .winner_valid_o(winner_valid_o),
        .winner_o(winner_o)
`ifdef SVM_DAG_PATH_EN
        , .dag_path_o(dag_path_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int lo; int hi;} pair_t;
    typedef struct {int win; int path;} win_t;
    pair_t exp_pairs[$];
    win_t  exp_wins[$];
    int checks = 0, errors = 0, cyc = 0, win_cnt = 0, win_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input int idx, input int lo, input int hi);
        pair_t p;
        p.idx = idx; p.lo = lo; p.hi = hi;
        exp_pairs.push_back(p);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor
    initial begin
        pair_t p;
        win_t  w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (svm_start_o) begin
                    if (exp_pairs.size() == 0) chk("unexpected_svm_start", 1, 0);
                    else begin
                        p = exp_pairs.pop_front();
                        chk("coef_idx", coef_idx_o, p.idx);
                        chk("cls_lo", cls_lo_o, p.lo);
                        chk("cls_hi", cls_hi_o, p.hi);
                    end
                end
                if (winner_valid_o) begin
                    win_cnt++;
                    win_cyc = cyc;
                    if (exp_wins.size() == 0) chk("unexpected_winner_valid", 1, 0);
                    else begin
                        w = exp_wins.pop_front();
                        chk("winner", winner_o, w.win);
                        chk("busy_at_winner", busy_o, 0);
`ifdef SVM_DAG_PATH_EN
                        chk("dag_path", dag_path_o, w.path);
`endif
                    end
                end
            end
        end
    end

    // One classification; the datapath answers one cycle after svm_start unless hold=1,
    // in which case svm_valid is raised already in the svm_start cycle and start is re-pulsed.
    task automatic run(input int cfg_v, input int nd, input logic [8:0] wv, input bit hold,
                       input int lat, input int exp_win, input int exp_path);
        int   w0, sc, t;
        win_t w;
        w0 = win_cnt;
        w.win = exp_win; w.path = exp_path;
        exp_wins.push_back(w);
        cfg = 5'(cfg_v); start = 1'b1; sc = cyc;
        tick();
        start = 1'b0;
        for (int d = 0; d < nd; d++) begin
            t = 0;
            while (!svm_start_o && t < 50) begin tick(); t++; end
            if (!svm_start_o) begin chk("svm_start_timeout", 0, 1); return; end
            if (hold) begin
                svm_valid = 1'b1; w_class = wv[d];
                if (d == 1) begin start = 1'b1; cfg = 5'd9; end
                tick();
                start = 1'b0;
                tick();
                svm_valid = 1'b0;
            end else begin
                tick();
                svm_valid = 1'b1; w_class = wv[d];
                tick();
                svm_valid = 1'b0;
            end
        end
        t = 0;
        while (win_cnt == w0 && t < 50) begin tick(); t++; end
        chk("winner_pulses", win_cnt - w0, 1);
        if (lat > 0) chk("latency", win_cyc - sc, lat);
        chk("pairs_left", exp_pairs.size(), 0);
        tick(); tick();
        chk("busy_after", busy_o, 0);
        chk("winner_held", winner_o, exp_win);
    endtask

    initial begin
        int t;
        repeat (3) tick();
        chk("rst_svm_start", svm_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_winner_valid", winner_valid_o, 0);
        chk("rst_winner", winner_o, 0);
        chk("rst_coef_idx", coef_idx_o, 0);
        chk("rst_cls_lo", cls_lo_o, 0);
        chk("rst_cls_hi", cls_hi_o, 0);
        rst = 1'b0;
        tick();

        // n=10, low class always wins
        for (int i = 0; i < 9; i++) push(i, 0, 9 - i);
        run(10, 9, 9'h000, 1'b0, 19, 0, 0);

        // n=10, high class always wins
        push(0, 0, 9); push(9, 1, 9); push(17, 2, 9); push(24, 3, 9); push(30, 4, 9);
        push(35, 5, 9); push(39, 6, 9); push(42, 7, 9); push(44, 8, 9);
        run(10, 9, 9'h1FF, 1'b0, 19, 9, 'h1FF);

        // n=4, w = 1,0,1
        push(0, 0, 3); push(3, 1, 3); push(4, 1, 2);
        run(4, 3, 9'b101, 1'b0, 7, 2, 'b101);

        // cfg=1 clamps to 2
        push(0, 0, 1);
        run(1, 1, 9'b1, 1'b0, 3, 1, 1);

        // cfg=12 clamps to 10, alternating decisions
        push(0, 0, 9); push(1, 0, 8); push(10, 1, 8); push(11, 1, 7); push(19, 2, 7);
        push(20, 2, 6); push(27, 3, 6); push(28, 3, 5); push(34, 4, 5);
        run(12, 9, 9'h0AA, 1'b0, 19, 4, 'h0AA);

        // start during EVAL and svm_valid held across the svm_start cycle
        push(0, 0, 3); push(3, 1, 3); push(4, 1, 2);
        run(4, 3, 9'b101, 1'b1, 0, 2, 'b101);

        // reset after the third decision
        for (int i = 0; i < 4; i++) push(i, 0, 9 - i);
        cfg = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            t = 0;
            while (!svm_start_o && t < 50) begin tick(); t++; end
            if (!svm_start_o) chk("svm_start_timeout_rst", 0, 1);
            tick();
            svm_valid = 1'b1; w_class = 1'b0;
            tick();
            svm_valid = 1'b0;
        end
        @(negedge clk); #1;
        rst = 1'b1;
        tick();
        chk("abort_svm_start", svm_start_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_winner_valid", winner_valid_o, 0);
        chk("abort_winner", winner_o, 0);
        chk("abort_coef_idx", coef_idx_o, 0);
        chk("abort_cls_lo", cls_lo_o, 0);
        chk("abort_cls_hi", cls_hi_o, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_pairs_left", exp_pairs.size(), 0);
        chk("abort_busy_idle", busy_o, 0);

        // clean run after abort
        push(0, 0, 3); push(3, 1, 3); push(4, 1, 2);
        run(4, 3, 9'b101, 1'b0, 7, 2, 'b101);

        chk("wins_left", exp_wins.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
